ppi_rx: RTL and testbench
=========================

PPI_RX -- requirements
Module: ppi_rx

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  FRAME_LEN  16  data words per PPI frame (range 2..256)
  FIFO_DEPTH  8  output buffer depth in words (power of two, range 4..64)
REQ-002 Ports (name  direction  width  meaning), one per line:
  clk  in  1  single clock; all inputs sampled and all outputs driven on its rising edge
  rst  in  1  asynchronous reset, active-high
  ppi_FS  in  1  frame sync; high in the same cycle as word 0 of a frame
  ppi_data  in  16  PPI data bus, one word per clk
  err_clr  in  1  synchronous clear of sticky error flags
  out_data  out  16  buffered word, head of FIFO
  out_valid  out  1  out_data holds a valid word
  out_last  out  1  out_data is the final data word of its frame
  out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high
  frame_done  out  1  one-cycle pulse when the final data word of a frame is captured
  frame_err  out  1  sticky: ppi_FS arrived mid-frame
  overflow  out  1  sticky: a word was dropped because the FIFO was full
  chk_err  out  1  one-cycle pulse on checksum mismatch (PPI_RX_CHECKSUM_EN only)

Function
REQ-003 The FSM SHALL have exactly two states, IDLE and RECV, plus a word counter of width clog2(FRAME_LEN+1).
REQ-004 In IDLE with ppi_FS=1, the block SHALL capture ppi_data as word 0, set the counter to 1, and enter RECV; with ppi_FS=0, ppi_data SHALL be ignored.
REQ-005 In RECV, the block SHALL capture ppi_data on every clk edge and increment the counter.
REQ-006 After the final word is captured, the block SHALL return to IDLE. The final word is word FRAME_LEN-1, or the checksum word when checksums are enabled.
REQ-007 ppi_FS=1 in RECV SHALL set frame_err and restart the frame: that cycle's word becomes word 0 and the counter becomes 1. Words of the aborted frame already in the FIFO SHALL remain there.
REQ-008 Each captured data word SHALL be pushed into the FIFO. out_last SHALL be stored alongside the word, set only for word FRAME_LEN-1.
REQ-009 Latency: the FIFO SHALL be first-word-fall-through. A word captured at edge N into an empty FIFO SHALL be presented on out_data with out_valid=1 from edge N+1.
REQ-010 A push while the FIFO is full and out_ready=0 SHALL drop the word and set overflow. Pointers and count SHALL be unchanged.
REQ-011 A push while the FIFO is full and a pop occurs in the same cycle SHALL succeed with no overflow.
REQ-012 Simultaneous push and pop on an empty FIFO SHALL NOT pop; the new word SHALL appear next cycle.
REQ-013 Pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL be tracked with a count of width clog2(FIFO_DEPTH)+1.
REQ-014 frame_done SHALL pulse in the cycle after the final data word is captured, whether or not the word was dropped.
REQ-015 err_clr=1 SHALL clear frame_err and overflow at the next edge. A same-cycle set SHALL win over the clear.
REQ-016 out_data SHALL hold its value while out_valid=1 and out_ready=0.

Reset
REQ-017 rst=1 SHALL asynchronously force the following, regardless of mid-frame state:
  FSM to IDLE; counter, FIFO pointers and count to 0.
  out_valid, out_last, frame_done, frame_err, overflow and chk_err to 0.
  out_data to 16'h0000.
REQ-018 After rst deasserts, the first frame SHALL be accepted only on a fresh ppi_FS.

Configuration
REQ-019 With macro PPI_RX_CHECKSUM_EN defined:
  each frame SHALL carry one extra word after word FRAME_LEN-1: the 16-bit sum, modulo 2^16, of the FRAME_LEN data words;
  the checksum word SHALL NOT be pushed into the FIFO;
  chk_err SHALL pulse one cycle after the checksum word is captured if it mismatches;
  frame_done SHALL pulse in that same cycle.
REQ-020 With PPI_RX_CHECKSUM_EN undefined:
  frames SHALL be FRAME_LEN words;
  chk_err SHALL be tied to 0;
  no accumulator SHALL be synthesised.

Structure
REQ-021 Package ppi_pkg SHALL hold PPI_W=16, the rx state enum typedef (IDLE, RECV), and the checksum width constant.
REQ-022 The FIFO SHALL be a separate sub-module, ppi_rx_fifo, parameterised by width 17 (data plus last) and FIFO_DEPTH.

Verification
REQ-023 The bench SHALL cover, with FRAME_LEN=4 and FIFO_DEPTH=8:
  - Basic frame: FS with words 1,2,3,4 back-to-back, out_ready=1 -> outputs 1,2,3,4; out_last only on 4; frame_done one pulse; first out_valid one cycle after capture of word 1.
  - Backpressure: out_ready=0, three frames of 4 (12 words) -> first 8 words kept, overflow=1; after err_clr -> overflow=0 and the FIFO drains 8 words.
  - Full plus pop: FIFO full, push with out_ready=1 in the same cycle -> no overflow, count stays 8.
  - Mid-frame FS: FS, A,B, then FS with C,D,E,F -> frame_err=1; output A,B,C,D,E,F; out_last only on F.
  - Reset mid-frame: rst pulse after word 2 -> all outputs 0; following words without FS ignored; next FS frame received intact.
  - With PPI_RX_CHECKSUM_EN: frame 1,2,3,4 plus checksum 10 -> chk_err=0; same frame with checksum 11 -> chk_err pulses; checksum word never appears on out_data.

Source files
------------

// File: rtl/ppi_pkg.sv
// rtl/ppi_pkg.sv - shared widths and receiver state type for the PPI receive path
package ppi_pkg;

    localparam int PPI_W = 16;
    localparam int CHK_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

endpackage

// File: rtl/ppi_rx_if.sv
// rtl/ppi_rx_if.sv - buffered word stream leaving the PPI receiver (valid/ready with last marker)
interface ppi_rx_if;

    logic [ppi_pkg::PPI_W-1:0] out_data;
    logic                      out_valid;
    logic                      out_last;
    logic                      out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/ppi_rx_fifo.sv
// rtl/ppi_rx_fifo.sv - first-word-fall-through buffer; a push into a full buffer only lands if a pop frees a slot
module ppi_rx_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop_req,
    output logic [W-1:0] rdata,
    output logic         valid,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem [DEPTH];

    logic full;
    logic pop;
    logic wr_en;

    assign valid = (count_q != '0);
    assign full  = (count_q == CW'(DEPTH));
    // An empty buffer never pops, so a same-cycle push simply appears next cycle.
    assign pop   = pop_req && valid;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;
    assign rdata = valid ? mem[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/ppi_rx.sv
// rtl/ppi_rx.sv - PPI frame receiver feeding a buffered word stream
// Optional trailing checksum word per frame is enabled by defining PPI_RX_CHECKSUM_EN.
module ppi_rx
    import ppi_pkg::*;
#(
    parameter int FRAME_LEN  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ppi_FS,
    input  logic [PPI_W-1:0] ppi_data,
    input  logic             err_clr,
    ppi_rx_if.master         out,
    output logic             frame_done,
    output logic             frame_err,
    output logic             overflow,
    output logic             chk_err
);

    localparam int CW = $clog2(FRAME_LEN + 1);
`ifdef PPI_RX_CHECKSUM_EN
    localparam int LAST_IDX = FRAME_LEN;
`else
    localparam int LAST_IDX = FRAME_LEN - 1;
`endif

    rx_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           frame_done_q, frame_done_d;
    logic           frame_err_q, frame_err_d;
    logic           overflow_q, overflow_d;

    logic           capture;
    logic           restart;
    logic [CW-1:0]  word_idx;
    logic           is_final;
    logic           push;
    logic           is_last;
    logic           drop;
    logic [PPI_W:0] fifo_rdata;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        restart  = 1'b0;
        word_idx = cnt_q;
        // A sync pulse always starts a fresh frame, even in the middle of one.
        if (ppi_FS) begin
            capture  = 1'b1;
            word_idx = '0;
            restart  = (state_q == RECV);
        end else if (state_q == RECV) begin
            capture = 1'b1;
        end
        is_final = capture && (word_idx == CW'(LAST_IDX));
        push     = capture && (word_idx < CW'(FRAME_LEN));
        is_last  = push && (word_idx == CW'(FRAME_LEN - 1));
        if (capture) begin
            if (is_final) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = RECV;
                cnt_d   = word_idx + CW'(1);
            end
        end
        frame_done_d = is_final;
        frame_err_d  = restart ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
        overflow_d   = drop    ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef PPI_RX_CHECKSUM_EN
    logic [CHK_W-1:0] sum_q, sum_d;
    logic             chk_err_q, chk_err_d;

    always_comb begin
        sum_d     = sum_q;
        chk_err_d = 1'b0;
        if (capture) begin
            if (word_idx == '0) begin
                sum_d = ppi_data;
            end else if (push) begin
                sum_d = sum_q + ppi_data;
            end else begin
                chk_err_d = (ppi_data != sum_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    ppi_rx_fifo #(
        .W     (PPI_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wdata   ({is_last, ppi_data}),
        .pop_req (out.out_ready),
        .rdata   (fifo_rdata),
        .valid   (out.out_valid),
        .drop    (drop)
    );

    assign out.out_data = fifo_rdata[PPI_W-1:0];
    assign out.out_last = fifo_rdata[PPI_W];
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ppi_rx.sv
// tb/tb_ppi_rx.sv - directed bench for ppi_rx with FRAME_LEN=4, FIFO_DEPTH=8
module tb_ppi_rx;

`ifdef PPI_RX_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ppi_FS;
    logic [15:0] ppi_data;
    logic        err_clr;
    logic        frame_done;
    logic        frame_err;
    logic        overflow;
    logic        chk_err;

    int checks = 0;
    int errors = 0;

    ppi_rx_if ob ();

    ppi_rx #(
        .FRAME_LEN  (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ppi_FS     (ppi_FS),
        .ppi_data   (ppi_data),
        .err_clr    (err_clr),
        .out        (ob),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_tail(input logic [15:0] s);
        if (CK) begin
            ppi_FS   = 1'b0;
            ppi_data = s;
            tick();
        end
    endtask

    initial begin
        logic [15:0] s;
        logic [15:0] mid_exp [6];

        rst          = 1'b1;
        ppi_FS       = 1'b0;
        ppi_data     = 16'h0;
        err_clr      = 1'b0;
        ob.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid",      32'(ob.out_valid),  0);
        chk("rst_data",       32'(ob.out_data),   0);
        chk("rst_last",       32'(ob.out_last),   0);
        chk("rst_frame_done", 32'(frame_done),    0);
        chk("rst_frame_err",  32'(frame_err),     0);
        chk("rst_overflow",   32'(overflow),      0);
        chk("rst_chk_err",    32'(chk_err),       0);
        rst = 1'b0;
        tick();

        ppi_data = 16'h55;
        tick();
        chk("idle_ignore", 32'(ob.out_valid), 0);

        // Basic frame
        ob.out_ready = 1'b1;
        ppi_FS = 1'b1; ppi_data = 16'd1;
        chk("basic_pre_valid", 32'(ob.out_valid), 0);
        tick();
        chk("basic_w1_valid", 32'(ob.out_valid), 1);
        chk("basic_w1_data",  32'(ob.out_data),  1);
        chk("basic_w1_last",  32'(ob.out_last),  0);
        ppi_FS = 1'b0; ppi_data = 16'd2;
        tick();
        chk("basic_w2_data", 32'(ob.out_data), 2);
        ppi_data = 16'd3;
        tick();
        chk("basic_w3_data", 32'(ob.out_data), 3);
        chk("basic_w3_last", 32'(ob.out_last), 0);
        chk("basic_w3_done", 32'(frame_done),  0);
        ppi_data = 16'd4;
        tick();
        chk("basic_w4_data", 32'(ob.out_data), 4);
        chk("basic_w4_last", 32'(ob.out_last), 1);
        chk("basic_w4_done", 32'(frame_done),  32'(!CK));
        send_tail(16'd10);
        chk("basic_done_pulse", 32'(frame_done), 1);
        ppi_FS = 1'b0; ppi_data = 16'h0;
        tick();
        chk("basic_done_clear", 32'(frame_done),   0);
        chk("basic_drained",    32'(ob.out_valid), 0);

        // Backpressure: three frames into an eight-deep buffer
        ob.out_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            s = 16'h0;
            for (int w = 0; w < 4; w++) begin
                ppi_FS   = (w == 0);
                ppi_data = 16'(16'h10 + f * 4 + w);
                s        = s + ppi_data;
                tick();
            end
            send_tail(s);
        end
        ppi_FS = 1'b0; ppi_data = 16'h0;
        chk("bp_overflow", 32'(overflow),            1);
        chk("bp_valid",    32'(ob.out_valid),        1);
        chk("bp_head",     32'(ob.out_data),         32'h10);
        chk("bp_count",    32'(dut.u_fifo.count_q),  8);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("bp_ovf_clr", 32'(overflow), 0);
        ob.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp_drain_data", 32'(ob.out_data), 32'(16'h10 + i));
            chk("bp_drain_last", 32'(ob.out_last), 32'(i % 4 == 3));
            tick();
        end
        chk("bp_empty", 32'(ob.out_valid), 0);

        // Full buffer with simultaneous pop
        ob.out_ready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            s = 16'h0;
            for (int w = 0; w < 4; w++) begin
                ppi_FS   = (w == 0);
                ppi_data = 16'(16'h20 + f * 4 + w);
                s        = s + ppi_data;
                tick();
            end
            send_tail(s);
        end
        chk("fp_count_full", 32'(dut.u_fifo.count_q), 8);
        chk("fp_head0",      32'(ob.out_data),        32'h20);
        ob.out_ready = 1'b1;
        ppi_FS = 1'b1; ppi_data = 16'h28;
        tick();
        chk("fp_no_overflow", 32'(overflow),            0);
        chk("fp_count",       32'(dut.u_fifo.count_q),  8);
        chk("fp_head1",       32'(ob.out_data),         32'h21);
        ppi_FS = 1'b0;
        for (int w = 1; w < 4; w++) begin
            ppi_data = 16'(16'h28 + w);
            tick();
        end
        ob.out_ready = 1'b0;
        send_tail(16'h28 + 16'h29 + 16'h2a + 16'h2b);
        ppi_data = 16'h0;
        chk("fp_count_end", 32'(dut.u_fifo.count_q), 8);
        chk("fp_ovf_end",   32'(overflow),           0);
        ob.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("fp_drain_data", 32'(ob.out_data), 32'(16'h24 + i));
            chk("fp_drain_last", 32'(ob.out_last), 32'(i % 4 == 3));
            tick();
        end
        chk("fp_empty", 32'(ob.out_valid), 0);

        // Mid-frame sync, with a clear in the same cycle as the error set
        ob.out_ready = 1'b0;
        ppi_FS = 1'b1; ppi_data = 16'hA; tick();
        ppi_FS = 1'b0; ppi_data = 16'hB; tick();
        chk("mf_err_before", 32'(frame_err), 0);
        ppi_FS = 1'b1; ppi_data = 16'hC; err_clr = 1'b1; tick();
        err_clr = 1'b0;
        chk("mf_set_wins", 32'(frame_err), 1);
        ppi_FS = 1'b0; ppi_data = 16'hD; tick();
        ppi_data = 16'hE; tick();
        ppi_data = 16'hF; tick();
        chk("mf_done", 32'(frame_done), 32'(!CK));
        send_tail(16'h36);
        ppi_data = 16'h0;
        chk("mf_err_sticky", 32'(frame_err), 1);
        mid_exp = '{16'hA, 16'hB, 16'hC, 16'hD, 16'hE, 16'hF};
        ob.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("mf_drain_data", 32'(ob.out_data), 32'(mid_exp[i]));
            chk("mf_drain_last", 32'(ob.out_last), 32'(i == 5));
            tick();
        end
        chk("mf_empty", 32'(ob.out_valid), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("mf_err_clr", 32'(frame_err), 0);

        // Asynchronous reset in the middle of a frame
        ob.out_ready = 1'b0;
        ppi_FS = 1'b1; ppi_data = 16'h31; tick();
        ppi_FS = 1'b0; ppi_data = 16'h32; tick();
        chk("rm_pre_valid", 32'(ob.out_valid), 1);
        chk("rm_pre_data",  32'(ob.out_data),  32'h31);
        #2;
        rst = 1'b1;
        #1;
        chk("rm_async_valid", 32'(ob.out_valid), 0);
        chk("rm_async_data",  32'(ob.out_data),  0);
        chk("rm_async_last",  32'(ob.out_last),  0);
        chk("rm_async_count", 32'(dut.u_fifo.count_q), 0);
        tick();
        rst = 1'b0;
        ppi_data = 16'h33; tick();
        ppi_data = 16'h34; tick();
        chk("rm_ignore", 32'(ob.out_valid), 0);
        ob.out_ready = 1'b1;
        ppi_FS = 1'b1; ppi_data = 16'h41; tick();
        chk("rm_w1_data", 32'(ob.out_data), 32'h41);
        ppi_FS = 1'b0;
        ppi_data = 16'h42; tick();
        ppi_data = 16'h43; tick();
        ppi_data = 16'h44; tick();
        chk("rm_w4_data", 32'(ob.out_data), 32'h44);
        chk("rm_w4_last", 32'(ob.out_last), 1);
        send_tail(16'h10A);
        ppi_data = 16'h0;
        tick();
        chk("rm_empty",   32'(ob.out_valid), 0);
        chk("rm_no_err",  32'(frame_err),    0);

`ifdef PPI_RX_CHECKSUM_EN
        // Checksum good then bad
        ob.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ppi_FS = 1'b1; ppi_data = 16'd1; tick();
            ppi_FS = 1'b0;
            ppi_data = 16'd2; tick();
            ppi_data = 16'd3; tick();
            ppi_data = 16'd4; tick();
            chk("ck_w4_data",  32'(ob.out_data), 4);
            chk("ck_w4_chk",   32'(chk_err),     0);
            ppi_data = 16'(10 + k); tick();
            chk("ck_chk_err",  32'(chk_err),      32'(k));
            chk("ck_done",     32'(frame_done),   1);
            chk("ck_not_pushed", 32'(ob.out_valid), 0);
            ppi_data = 16'h0; tick();
            chk("ck_chk_clear", 32'(chk_err), 0);
        end
`else
        chk("chk_err_tied", 32'(chk_err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
